// File: rtl/expr_pkg.sv
// expr_pkg: shared state encodings, character constants and grammar step for the expression arbiter
package expr_pkg;

    typedef enum logic [1:0] {IDLE, STREAM, RESULT} arb_state_t;

    typedef enum logic [1:0] {CK_START, CK_NUM, CK_OP, CK_ERR} ck_state_t;

    localparam logic [7:0] CH_PLUS = 8'h2B;
    localparam logic [7:0] CH_STAR = 8'h2A;
    localparam logic [7:0] CH_0    = 8'h30;
    localparam logic [7:0] CH_9    = 8'h39;

    // Operands are single digits, so a digit directly after a digit is an error
    function automatic ck_state_t ck_next(input ck_state_t s, input logic [7:0] ch);
        logic dig;
        logic op;
        dig = (ch >= CH_0) && (ch <= CH_9);
        op  = (ch == CH_PLUS) || (ch == CH_STAR);
        return (s == CK_ERR) ? CK_ERR :
               dig           ? ((s == CK_NUM) ? CK_ERR : CK_NUM) :
               (op && s == CK_NUM) ? CK_OP : CK_ERR;
    endfunction

endpackage

// File: rtl/expr_check.sv
// expr_check: expression grammar recognizer with a saturating frame length counter
module expr_check #(
    parameter int MAX_LEN = 16
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       sclr,
    input  logic       en,
    input  logic [7:0] ch,
    output logic       ok
);
    import expr_pkg::*;

    localparam int LW = $clog2(MAX_LEN + 2);
    localparam logic [LW-1:0] LEN_SAT = LW'(MAX_LEN + 1);
    localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);

    ck_state_t ck;
    logic [LW-1:0] len;

    // Length parks at MAX_LEN+1 so any overlong frame stays rejected however long it runs
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ck  <= CK_START;
            len <= '0;
        end else if (sclr) begin
            ck  <= CK_START;
            len <= '0;
        end else if (en) begin
            ck  <= ck_next(ck, ch);
            len <= (len == LEN_SAT) ? len : len + 1'b1;
        end
    end

    assign ok = (ck == CK_NUM) && (len <= LEN_MAX);

endmodule

// File: rtl/expr_arbiter.sv
// expr_arbiter: round-robin owner of a single shared expression checker, one verdict per frame
module expr_arbiter #(
    parameter int MAX_LEN = 16
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [1:0] req_valid,
    input  logic [7:0] req_char0,
    input  logic [7:0] req_char1,
    input  logic [1:0] req_last,
    output logic [1:0] req_ready,
    output logic [1:0] res_valid,
    output logic       res_ok,
    output logic       busy,
    output logic       grant_id
);
    import expr_pkg::*;

    arb_state_t state;
    logic rr;
    logic ok;
    logic sclr;
    logic en;
    logic [7:0] ch;
    logic [1:0] own;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state    <= IDLE;
            rr       <= 1'b0;
            grant_id <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|req_valid) begin
                    grant_id <= (&req_valid) ? rr : req_valid[1];
                    state    <= STREAM;
                end
                STREAM: if (req_valid[grant_id] && req_last[grant_id]) state <= RESULT;
                RESULT: begin
                    rr    <= ~grant_id;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The checker is wiped on the same edge that picks the new owner
    assign sclr = (state == IDLE) && (|req_valid);
    assign en   = (state == STREAM) && req_valid[grant_id];
    assign ch   = grant_id ? req_char1 : req_char0;
    assign own  = grant_id ? 2'b10 : 2'b01;

    expr_check #(.MAX_LEN(MAX_LEN)) u_check (
        .clk  (clk),
        .clr  (clr),
        .sclr (sclr),
        .en   (en),
        .ch   (ch),
        .ok   (ok)
    );

    assign req_ready = (state == STREAM) ? own : 2'b00;
    assign res_valid = (state == RESULT) ? own : 2'b00;
    assign res_ok    = (state == RESULT) && ok;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_expr_arbiter.sv
// tb_expr_arbiter: scenario tasks plus randomized frames checked against a grammar-level reference model
module tb_expr_arbiter;

    localparam int MAX_LEN = 16;
    typedef logic [7:0] ch_t;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [1:0] req_valid = 2'b00;
    logic [7:0] req_char0 = 8'h00;
    logic [7:0] req_char1 = 8'h00;
    logic [1:0] req_last = 2'b00;
    logic [1:0] req_ready;
    logic [1:0] res_valid;
    logic       res_ok;
    logic       busy;
    logic       grant_id;

    int vectors = 0;
    int miscompares = 0;

    expr_arbiter #(.MAX_LEN(MAX_LEN)) dut (
        .clk       (clk),
        .clr       (clr),
        .req_valid (req_valid),
        .req_char0 (req_char0),
        .req_char1 (req_char1),
        .req_last  (req_last),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ok    (res_ok),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // A frame is good when it reads digit (op digit)* and is no longer than MAX_LEN
    function automatic bit model_ok(input ch_t f[$]);
        if (f.size() == 0 || f.size() > MAX_LEN || f.size() % 2 == 0) return 1'b0;
        foreach (f[i]) begin
            if (i % 2 == 0 && !(f[i] >= "0" && f[i] <= "9")) return 1'b0;
            if (i % 2 == 1 && f[i] != "+" && f[i] != "*") return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic send_frame(input int r, input ch_t f[$], input int gap_at, input int gap_len,
                              input bit other, input bit rnd_gap);
        int idx;
        int cyc;
        int first;
        int gap;
        bit exp_ok;
        logic [1:0] own;
        idx = 0; cyc = 0; first = -1; gap = 0;
        exp_ok = model_ok(f);
        own = (r == 1) ? 2'b10 : 2'b01;
        while (idx < f.size() && cyc < 400) begin
            if (first >= 0 && idx == gap_at && gap < gap_len) begin
                req_valid[r] = 1'b0;
                gap++;
                if (other) begin
                    req_valid[1-r] = 1'b1;
                    req_last[1-r] = 1'b1;
                    if (r == 0) req_char1 = "9"; else req_char0 = "9";
                end
            end else if (rnd_gap && first >= 0 && $urandom_range(0, 4) == 0) begin
                req_valid[r] = 1'b0;
            end else begin
                req_valid[r] = 1'b1;
                req_last[r] = (idx == f.size() - 1);
                if (r == 0) req_char0 = f[idx]; else req_char1 = f[idx];
            end
            if (req_ready[r] && first < 0) first = cyc;
            if (first >= 0) begin
                vectors++;
                if (req_ready !== own || busy !== 1'b1 || grant_id !== own[1]) begin
                    miscompares++;
                    $display("FAIL stream r%0d: ready=%b busy=%b grant=%b, want ready=%b busy=1 grant=%b",
                             r, req_ready, busy, grant_id, own, own[1]);
                end
            end
            if (req_ready[r] && req_valid[r]) idx++;
            tick();
            cyc++;
        end
        vectors++;
        if (idx < f.size() || first != 1) begin
            miscompares++;
            $display("FAIL grant r%0d: sent %0d of %0d chars, first ready after %0d cycles, want all sent after 1",
                     r, idx, f.size(), first);
        end
        req_valid[r] = 1'b0;
        req_last[r] = 1'b0;
        vectors++;
        if (res_valid !== own || res_ok !== exp_ok) begin
            miscompares++;
            $display("FAIL verdict r%0d len %0d: res_valid=%b res_ok=%b, want res_valid=%b res_ok=%b",
                     r, f.size(), res_valid, res_ok, own, exp_ok);
        end
        tick();
        vectors++;
        if (res_valid !== 2'b00 || req_ready !== 2'b00 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL gap r%0d: res_valid=%b ready=%b busy=%b, want 00 00 0",
                     r, res_valid, req_ready, busy);
        end
    endtask

    task automatic send_str(input int r, input string s);
        ch_t q[$];
        for (int i = 0; i < s.len(); i++) q.push_back(ch_t'(s[i]));
        send_frame(r, q, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic check_idle_outputs(input string name);
        vectors++;
        if (req_ready !== 2'b00 || res_valid !== 2'b00 || res_ok !== 1'b0 || busy !== 1'b0 || grant_id !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: ready=%b res_valid=%b res_ok=%b busy=%b grant=%b, want 00 00 0 0 0",
                     name, req_ready, res_valid, res_ok, busy, grant_id);
        end
    endtask

    task automatic test_reset();
        clr = 1'b1;
        repeat (2) tick();
        check_idle_outputs("reset");
        clr = 1'b0;
        tick();
        check_idle_outputs("post_reset_idle");
    endtask

    task automatic test_basic();
        send_str(0, "1+2*3");
        send_str(1, "1+");
        send_str(1, "12");
        send_str(1, "a");
    endtask

    task automatic test_contention();
        logic last_served;
        logic [1:0] exp_rdy;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        last_served = 1'b1;
        req_char0 = "5"; req_char1 = "6"; req_last = 2'b11; req_valid = 2'b11;
        for (int k = 0; k < 3; k++) begin
            tick();
            exp_rdy = last_served ? 2'b01 : 2'b10;
            vectors++;
            if (req_ready !== exp_rdy) begin
                miscompares++;
                $display("FAIL contention%0d ready: got %b, want %b", k, req_ready, exp_rdy);
            end
            tick();
            vectors++;
            if (res_valid !== exp_rdy || res_ok !== 1'b1) begin
                miscompares++;
                $display("FAIL contention%0d verdict: res_valid=%b res_ok=%b, want %b 1", k, res_valid, res_ok, exp_rdy);
            end
            last_served = ~last_served;
            if (k == 0) req_valid[0] = 1'b0;
            else if (k == 1) req_valid[0] = 1'b1;
            tick();
            vectors++;
            if (req_ready !== 2'b00 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL contention%0d gap: ready=%b busy=%b, want 00 0", k, req_ready, busy);
            end
        end
        req_valid = 2'b00;
        req_last = 2'b00;
        tick();
    endtask

    task automatic test_stall();
        ch_t q[$];
        q = '{"3", "*", "4"};
        send_frame(0, q, 2, 5, 1'b1, 1'b0);
        q = '{"9"};
        send_frame(1, q, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_length();
        int lens[3] = '{15, 17, 33};
        ch_t q[$];
        foreach (lens[j]) begin
            q = {};
            for (int i = 0; i < lens[j]; i++) q.push_back((i % 2 == 1) ? ch_t'("+") : ch_t'("1"));
            send_frame(j % 2, q, 0, 0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_clr();
        req_char0 = "1"; req_last[0] = 1'b0; req_valid[0] = 1'b1;
        tick();
        tick();
        req_char0 = "+";
        tick();
        req_char0 = "2";
        vectors++;
        if (req_ready !== 2'b01) begin
            miscompares++;
            $display("FAIL clr_setup ready: got %b, want 01", req_ready);
        end
        #2 clr = 1'b1;
        #1;
        check_idle_outputs("clr_async");
        req_valid = 2'b00;
        tick();
        tick();
        check_idle_outputs("clr_held");
        clr = 1'b0;
        send_str(0, "7");
    endtask

    task automatic test_random();
        string pool = "0123456789+*a/";
        ch_t q[$];
        int r;
        int len;
        int mode;
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 1);
            len = $urandom_range(1, 20);
            mode = $urandom_range(0, 2);
            q = {};
            for (int i = 0; i < len; i++) begin
                if (mode == 1 || (mode == 2 && i == len / 2))
                    q.push_back(ch_t'(pool[$urandom_range(0, 13)]));
                else if (i % 2 == 1)
                    q.push_back(($urandom_range(0, 1) == 1) ? ch_t'("+") : ch_t'("*"));
                else
                    q.push_back(ch_t'(8'h30 + $urandom_range(0, 9)));
            end
            send_frame(r, q, 0, 0, 1'b0, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_contention();
        test_stall();
        test_length();
        test_clr();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
